// File: rtl/ex_mem_trap_reg_pkg.sv
// Shared types and constants for the EX/MEM pipeline register with overflow trap.
// Holds the FSM state encoding, the trap cause codes and the default widths.
package ex_mem_trap_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PC_W_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    TRAP_ISSUE = 2'd1,
    TRAP_WAIT  = 2'd2
  } trap_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_OVF  = 2'd1;

  // MEM/WB control bits carried through the register; a bubble zeroes all of them.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/ex_mem_trap_reg_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register as one bundle.
// The EX stage (master) drives ex_* and observes mem_*; the register (slave) does the reverse.
interface ex_mem_trap_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid_i;
  logic [PC_W-1:0]   ex_pc_i;
  logic [DATA_W-1:0] ex_alu_result_i;
  logic              ex_zero_i;
  logic              ex_overflow_i;
  logic              ex_ovf_chk_i;
  logic [DATA_W-1:0] ex_rt_data_i;
  logic [REG_AW-1:0] ex_wr_reg_i;
  logic              ex_reg_write_i;
  logic              ex_mem_read_i;
  logic              ex_mem_write_i;
  logic              ex_mem_to_reg_i;
  logic              ex_branch_i;

  logic              mem_valid_o;
  logic [PC_W-1:0]   mem_pc_o;
  logic [DATA_W-1:0] mem_alu_result_o;
  logic              mem_zero_o;
  logic [DATA_W-1:0] mem_rt_data_o;
  logic [REG_AW-1:0] mem_wr_reg_o;
  logic              mem_reg_write_o;
  logic              mem_mem_read_o;
  logic              mem_mem_write_o;
  logic              mem_mem_to_reg_o;
  logic              mem_branch_o;

  modport master (
    output ex_valid_i, ex_pc_i, ex_alu_result_i, ex_zero_i, ex_overflow_i, ex_ovf_chk_i,
           ex_rt_data_i, ex_wr_reg_i, ex_reg_write_i, ex_mem_read_i, ex_mem_write_i,
           ex_mem_to_reg_i, ex_branch_i,
    input  mem_valid_o, mem_pc_o, mem_alu_result_o, mem_zero_o, mem_rt_data_o, mem_wr_reg_o,
           mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o, mem_branch_o
  );

  modport slave (
    input  ex_valid_i, ex_pc_i, ex_alu_result_i, ex_zero_i, ex_overflow_i, ex_ovf_chk_i,
           ex_rt_data_i, ex_wr_reg_i, ex_reg_write_i, ex_mem_read_i, ex_mem_write_i,
           ex_mem_to_reg_i, ex_branch_i,
    output mem_valid_o, mem_pc_o, mem_alu_result_o, mem_zero_o, mem_rt_data_o, mem_wr_reg_o,
           mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o, mem_branch_o
  );
endinterface

// File: rtl/ex_mem_trap_reg_ovf_trap_fsm.sv
// Overflow trap sequencer: decides hold/bubble for the EX/MEM register, captures
// EPC and cause, counts traps and issues a one-cycle flush before waiting for the handler.
module ovf_trap_fsm
  import ex_mem_trap_reg_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic             ex_ovf_chk_i,
  input  logic             ex_overflow_i,
  input  logic [PC_W-1:0]  ex_pc_i,
  input  logic             mem_stall_i,
  input  logic             flush_i,
  input  logic             trap_ack_i,
  output logic             load_en_o,
  output logic             bubble_o,
  output logic             trap_flush_o,
  output logic             trap_pending_o,
  output logic [PC_W-1:0]  epc_o,
  output logic [1:0]       cause_o,
  output logic [CNT_W-1:0] ovf_count_o,
  output trap_state_e      state_o
);

  trap_state_e      state_q;
  logic             trap_flush_q;
  logic             trap_pending_q;
  logic [PC_W-1:0]  epc_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] ovf_count_q;
  logic             trap_hit;
  logic             trap_take;

  assign trap_hit  = ex_valid_i & ex_ovf_chk_i & ex_overflow_i;
  // Stall outranks flush, and flush outranks trap, so a trap is only taken on a free RUN cycle.
  assign trap_take = (state_q == RUN) & ~mem_stall_i & ~flush_i & trap_hit;

  always_comb begin
    load_en_o = 1'b1;
    bubble_o  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall_i)             load_en_o = 1'b0;
        else if (flush_i || trap_hit) bubble_o  = 1'b1;
      end
      default: bubble_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      trap_flush_q   <= 1'b0;
      trap_pending_q <= 1'b0;
      epc_q          <= '0;
      cause_q        <= CAUSE_NONE;
      ovf_count_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (trap_take) begin
            state_q        <= TRAP_ISSUE;
            trap_flush_q   <= 1'b1;
            trap_pending_q <= 1'b1;
            epc_q          <= ex_pc_i;
            cause_q        <= CAUSE_OVF;
            if (ovf_count_q != {CNT_W{1'b1}}) ovf_count_q <= ovf_count_q + CNT_W'(1);
          end
        end
        TRAP_ISSUE: begin
          state_q      <= TRAP_WAIT;
          trap_flush_q <= 1'b0;
        end
        TRAP_WAIT: begin
          if (trap_ack_i) begin
            state_q        <= RUN;
            trap_pending_q <= 1'b0;
            cause_q        <= CAUSE_NONE;
          end
        end
        default: begin
          state_q        <= RUN;
          trap_flush_q   <= 1'b0;
          trap_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign trap_flush_o   = trap_flush_q;
  assign trap_pending_o = trap_pending_q;
  assign epc_o          = epc_q;
  assign cause_o        = cause_q;
  assign ovf_count_o    = ovf_count_q;
  assign state_o        = state_q;

endmodule

// File: rtl/ex_mem_trap_reg.sv
// EX/MEM pipeline register downstream of the 32-bit ALU. Latches result, flags,
// store data and MEM/WB control, and turns checked signed overflow into a trap.
module ex_mem_trap_reg
  import ex_mem_trap_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ex_mem_trap_reg_if.slave  bus,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic              trap_ack_i,
  output logic              trap_flush_o,
  output logic              trap_pending_o,
  output logic [PC_W-1:0]   epc_o,
  output logic [1:0]        cause_o,
  output logic [CNT_W-1:0]  ovf_count_o,
  output logic [1:0]        dbg_state_o
);

  logic              load_en;
  logic              bubble;
  trap_state_e       state;
  ctrl_t             ex_ctrl;

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] alu_result_q;
  logic              zero_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [REG_AW-1:0] wr_reg_q;
  ctrl_t             ctrl_q;

  ovf_trap_fsm #(.PC_W(PC_W), .CNT_W(CNT_W)) u_fsm (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ex_valid_i     (bus.ex_valid_i),
    .ex_ovf_chk_i   (bus.ex_ovf_chk_i),
    .ex_overflow_i  (bus.ex_overflow_i),
    .ex_pc_i        (bus.ex_pc_i),
    .mem_stall_i    (mem_stall_i),
    .flush_i        (flush_i),
    .trap_ack_i     (trap_ack_i),
    .load_en_o      (load_en),
    .bubble_o       (bubble),
    .trap_flush_o   (trap_flush_o),
    .trap_pending_o (trap_pending_o),
    .epc_o          (epc_o),
    .cause_o        (cause_o),
    .ovf_count_o    (ovf_count_o),
    .state_o        (state)
  );

  assign ex_ctrl = '{reg_write:  bus.ex_reg_write_i,
                     mem_read:   bus.ex_mem_read_i,
                     mem_write:  bus.ex_mem_write_i,
                     mem_to_reg: bus.ex_mem_to_reg_i,
                     branch:     bus.ex_branch_i};

  // Data fields still load on a bubble; only valid and control are forced off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      rt_data_q    <= '0;
      wr_reg_q     <= '0;
      ctrl_q       <= '0;
    end else if (load_en) begin
      valid_q      <= bus.ex_valid_i & ~bubble;
      pc_q         <= bus.ex_pc_i;
      alu_result_q <= bus.ex_alu_result_i;
      zero_q       <= bus.ex_zero_i;
      rt_data_q    <= bus.ex_rt_data_i;
      wr_reg_q     <= bus.ex_wr_reg_i;
      ctrl_q       <= bubble ? '0 : ex_ctrl;
    end
  end

  assign bus.mem_valid_o      = valid_q;
  assign bus.mem_pc_o         = pc_q;
  assign bus.mem_alu_result_o = alu_result_q;
  assign bus.mem_zero_o       = zero_q;
  assign bus.mem_rt_data_o    = rt_data_q;
  assign bus.mem_wr_reg_o     = wr_reg_q;
  assign bus.mem_reg_write_o  = ctrl_q.reg_write;
  assign bus.mem_mem_read_o   = ctrl_q.mem_read;
  assign bus.mem_mem_write_o  = ctrl_q.mem_write;
  assign bus.mem_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign bus.mem_branch_o     = ctrl_q.branch;
  assign dbg_state_o          = state;

endmodule

// File: tb/tb_ex_mem_trap_reg.sv
// Directed bench for ex_mem_trap_reg: one task per scenario with inline checks
// against hand-computed values; inputs change 1ns after the rising edge.
module tb_ex_mem_trap_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_stall = 1'b0;
  logic        flush = 1'b0;
  logic        trap_ack = 1'b0;
  logic        trap_flush;
  logic        trap_pending;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic [7:0]  ovf_count;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;

  ex_mem_trap_reg_if #(.DATA_W(32), .PC_W(32), .REG_AW(5)) bus ();

  ex_mem_trap_reg #(.DATA_W(32), .PC_W(32), .REG_AW(5), .CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus.slave),
    .mem_stall_i    (mem_stall),
    .flush_i        (flush),
    .trap_ack_i     (trap_ack),
    .trap_flush_o   (trap_flush),
    .trap_pending_o (trap_pending),
    .epc_o          (epc),
    .cause_o        (cause),
    .ovf_count_o    (ovf_count),
    .dbg_state_o    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: valid, pc, result, zero, overflow, ovf_chk, rt_data, wr_reg, {rw,mr,mw,m2r,br}
  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] res,
                          input logic z, input logic ovf, input logic chk,
                          input logic [31:0] rt, input logic [4:0] wr, input logic [4:0] ctrl);
    bus.ex_valid_i      = v;
    bus.ex_pc_i         = pc;
    bus.ex_alu_result_i = res;
    bus.ex_zero_i       = z;
    bus.ex_overflow_i   = ovf;
    bus.ex_ovf_chk_i    = chk;
    bus.ex_rt_data_i    = rt;
    bus.ex_wr_reg_i     = wr;
    {bus.ex_reg_write_i, bus.ex_mem_read_i, bus.ex_mem_write_i,
     bus.ex_mem_to_reg_i, bus.ex_branch_i} = ctrl;
  endtask

  function automatic logic [153:0] all_outputs();
    return {bus.mem_valid_o, bus.mem_pc_o, bus.mem_alu_result_o, bus.mem_zero_o,
            bus.mem_rt_data_o, bus.mem_wr_reg_o, bus.mem_reg_write_o, bus.mem_mem_read_o,
            bus.mem_mem_write_o, bus.mem_mem_to_reg_o, bus.mem_branch_o,
            trap_flush, trap_pending, epc, cause, ovf_count, dbg_state};
  endfunction

  function automatic logic [4:0] mem_ctrl();
    return {bus.mem_reg_write_o, bus.mem_mem_read_o, bus.mem_mem_write_o,
            bus.mem_mem_to_reg_o, bus.mem_branch_o};
  endfunction

  task automatic test_reset();
    logic [153:0] obs;
    drive_ex(1'b1, 32'hDEAD_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h1, 5'd31, 5'b11111);
    rst = 1'b1; mem_stall = 1'b1; flush = 1'b1; trap_ack = 1'b1;
    step(); step();
    obs = all_outputs();
    total++; if (obs !== '0) $display("FAIL reset_outputs: got %h want 0", obs); else passed++;
    rst = 1'b0; mem_stall = 1'b0; flush = 1'b0; trap_ack = 1'b0;
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'b00000);
    step();
  endtask

  task automatic test_normal();
    drive_ex(1'b1, 32'h40, 32'h1234, 1'b0, 1'b0, 1'b0, 32'hCAFE, 5'd5, 5'b10000);
    step();
    total++; if (bus.mem_valid_o !== 1'b1) $display("FAIL normal_valid: got %0h want 1", bus.mem_valid_o); else passed++;
    total++; if (bus.mem_alu_result_o !== 32'h1234) $display("FAIL normal_result: got %h want 00001234", bus.mem_alu_result_o); else passed++;
    total++; if (bus.mem_wr_reg_o !== 5'd5) $display("FAIL normal_wr_reg: got %0d want 5", bus.mem_wr_reg_o); else passed++;
    total++; if (bus.mem_pc_o !== 32'h40) $display("FAIL normal_pc: got %h want 00000040", bus.mem_pc_o); else passed++;
    total++; if (mem_ctrl() !== 5'b10000) $display("FAIL normal_ctrl: got %b want 10000", mem_ctrl()); else passed++;
    total++; if (trap_pending !== 1'b0) $display("FAIL normal_pending: got %0h want 0", trap_pending); else passed++;
  endtask

  task automatic test_back_to_back();
    drive_ex(1'b1, 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A, 5'd9, 5'b01011);
    step();
    total++; if ({bus.mem_zero_o, bus.mem_rt_data_o, bus.mem_wr_reg_o} !== {1'b1, 32'hA5A5_5A5A, 5'd9})
      $display("FAIL b2b_first: got %0h/%h/%0d want 1/a5a55a5a/9", bus.mem_zero_o, bus.mem_rt_data_o, bus.mem_wr_reg_o); else passed++;
    total++; if (mem_ctrl() !== 5'b01011) $display("FAIL b2b_first_ctrl: got %b want 01011", mem_ctrl()); else passed++;
    drive_ex(1'b1, 32'h48, 32'h7777, 1'b0, 1'b0, 1'b0, 32'h1, 5'd12, 5'b00100);
    step();
    total++; if ({bus.mem_pc_o, bus.mem_alu_result_o, mem_ctrl()} !== {32'h48, 32'h7777, 5'b00100})
      $display("FAIL b2b_second: got %h/%h/%b want 48/7777/00100", bus.mem_pc_o, bus.mem_alu_result_o, mem_ctrl()); else passed++;
  endtask

  task automatic test_checked_ovf();
    drive_ex(1'b1, 32'h80, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h0, 5'd7, 5'b10000);
    step();
    total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL ovf_valid: got %0h want 0", bus.mem_valid_o); else passed++;
    total++; if (bus.mem_reg_write_o !== 1'b0) $display("FAIL ovf_reg_write: got %0h want 0", bus.mem_reg_write_o); else passed++;
    total++; if (epc !== 32'h80) $display("FAIL ovf_epc: got %h want 00000080", epc); else passed++;
    total++; if (cause !== 2'd1) $display("FAIL ovf_cause: got %0d want 1", cause); else passed++;
    total++; if (trap_flush !== 1'b1) $display("FAIL ovf_flush_pulse: got %0h want 1", trap_flush); else passed++;
    total++; if (ovf_count !== 8'd1) $display("FAIL ovf_count: got %0d want 1", ovf_count); else passed++;
    total++; if (trap_pending !== 1'b1) $display("FAIL ovf_pending_issue: got %0h want 1", trap_pending); else passed++;
    step();
    total++; if (trap_flush !== 1'b0) $display("FAIL ovf_flush_drop: got %0h want 0", trap_flush); else passed++;
    total++; if (trap_pending !== 1'b1) $display("FAIL ovf_pending_wait: got %0h want 1", trap_pending); else passed++;
    total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL ovf_valid_issue: got %0h want 0", bus.mem_valid_o); else passed++;
  endtask

  task automatic test_ack();
    drive_ex(1'b1, 32'h84, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 5'b10100);
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if ({bus.mem_valid_o, mem_ctrl(), trap_pending} !== 7'b0000001)
        $display("FAIL ack_wait_%0d: got v=%0h c=%b p=%0h want v=0 c=00000 p=1", i, bus.mem_valid_o, mem_ctrl(), trap_pending); else passed++;
    end
    trap_ack = 1'b1; mem_stall = 1'b1;
    step();
    trap_ack = 1'b0; mem_stall = 1'b0;
    total++; if (trap_pending !== 1'b0) $display("FAIL ack_pending: got %0h want 0", trap_pending); else passed++;
    total++; if (cause !== 2'd0) $display("FAIL ack_cause: got %0d want 0", cause); else passed++;
    total++; if (epc !== 32'h80) $display("FAIL ack_epc: got %h want 00000080", epc); else passed++;
    total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL ack_valid: got %0h want 0", bus.mem_valid_o); else passed++;
    drive_ex(1'b1, 32'h88, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 5'd6, 5'b10000);
    step();
    total++; if ({bus.mem_valid_o, bus.mem_alu_result_o, bus.mem_wr_reg_o} !== {1'b1, 32'h55, 5'd6})
      $display("FAIL ack_resume: got %0h/%h/%0d want 1/00000055/6", bus.mem_valid_o, bus.mem_alu_result_o, bus.mem_wr_reg_o); else passed++;
  endtask

  task automatic test_unchecked_ovf();
    drive_ex(1'b1, 32'h8C, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 32'hBEEF, 5'd0, 5'b00100);
    step();
    total++; if ({bus.mem_valid_o, bus.mem_mem_write_o, bus.mem_pc_o} !== {1'b1, 1'b1, 32'h8C})
      $display("FAIL unchk_load: got %0h/%0h/%h want 1/1/0000008c", bus.mem_valid_o, bus.mem_mem_write_o, bus.mem_pc_o); else passed++;
    total++; if ({trap_pending, trap_flush} !== 2'b00) $display("FAIL unchk_no_trap: got %b want 00", {trap_pending, trap_flush}); else passed++;
    total++; if (ovf_count !== 8'd1) $display("FAIL unchk_count: got %0d want 1", ovf_count); else passed++;
  endtask

  task automatic test_stall_flush();
    mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_ex(1'b1, 32'h100 + 32'(i * 4), 32'h9 + 32'(i), 1'b1, 1'b1, 1'b1, 32'h0, 5'd1, 5'b11111);
      step();
      total++; if ({bus.mem_valid_o, bus.mem_pc_o, bus.mem_mem_write_o, trap_pending, ovf_count, epc} !== {1'b1, 32'h8C, 1'b1, 1'b0, 8'd1, 32'h80})
        $display("FAIL stall_hold_%0d: got v=%0h pc=%h mw=%0h p=%0h cnt=%0d epc=%h want 1/8c/1/0/1/80", i,
                 bus.mem_valid_o, bus.mem_pc_o, bus.mem_mem_write_o, trap_pending, ovf_count, epc); else passed++;
    end
    mem_stall = 1'b0; flush = 1'b1;
    drive_ex(1'b1, 32'h200, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 5'b11111);
    step();
    total++; if ({bus.mem_valid_o, mem_ctrl()} !== 6'b0) $display("FAIL flush_bubble: got v=%0h c=%b want 0/00000", bus.mem_valid_o, mem_ctrl()); else passed++;
    drive_ex(1'b1, 32'h204, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0, 5'd2, 5'b10000);
    step();
    flush = 1'b0;
    total++; if ({bus.mem_valid_o, mem_ctrl(), trap_pending, trap_flush} !== 8'b0) $display("FAIL flush_trap_bubble: got v=%0h c=%b p=%0h f=%0h want all 0", bus.mem_valid_o, mem_ctrl(), trap_pending, trap_flush); else passed++;
    total++; if ({epc, ovf_count} !== {32'h80, 8'd1}) $display("FAIL flush_trap_no_capture: got epc=%h cnt=%0d want 80/1", epc, ovf_count); else passed++;
  endtask

  task automatic test_saturation();
    int exp_cnt = 1;
    for (int i = 0; i < 256; i++) begin
      drive_ex(1'b1, 32'h1000 + 32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 5'd4, 5'b10000);
      step();
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      total++; if ({ovf_count, epc} !== {8'(exp_cnt), 32'h1000 + 32'(i * 4)})
        $display("FAIL sat_trap_%0d: got cnt=%0d epc=%h want cnt=%0d epc=%h", i, ovf_count, epc, exp_cnt, 32'h1000 + 32'(i * 4)); else passed++;
      drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'b00000);
      step();
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      total++; if (trap_pending !== 1'b0) $display("FAIL sat_ack_%0d: got %0h want 0", i, trap_pending); else passed++;
    end
    total++; if (ovf_count !== 8'd255) $display("FAIL sat_final: got %0d want 255", ovf_count); else passed++;
  endtask

  task automatic test_reset_in_trap();
    logic [153:0] obs;
    drive_ex(1'b1, 32'h3000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 5'd8, 5'b10000);
    step();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    total++; if ({trap_pending, trap_flush, dbg_state} !== {1'b1, 1'b0, 2'd2})
      $display("FAIL issue_ignores_ack: got p=%0h f=%0h s=%0d want 1/0/2", trap_pending, trap_flush, dbg_state); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs = all_outputs();
    total++; if (obs !== '0) $display("FAIL reset_in_wait: got %h want 0", obs); else passed++;
    drive_ex(1'b1, 32'h3004, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 5'd8, 5'b10000);
    step();
    total++; if ({ovf_count, epc, cause} !== {8'd1, 32'h3004, 2'd1})
      $display("FAIL post_reset_trap: got cnt=%0d epc=%h cause=%0d want 1/3004/1", ovf_count, epc, cause); else passed++;
  endtask

  initial begin
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'b00000);
    test_reset();
    test_normal();
    test_back_to_back();
    test_checked_ovf();
    test_ack();
    test_unchecked_ovf();
    test_stall_flush();
    test_saturation();
    test_reset_in_trap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_mem_trap_reg.md
Name: ex_mem_trap_reg

Overview:
EX/MEM pipeline register placed directly downstream of the 32-bit ALU built from the ALU bit slices. It latches the ALU result, the zero flag, the store data and the MEM/WB control bits. It also consumes the ALU overflow flag. On a checked signed overflow it suppresses the faulting instruction, records its EPC and cause, pulses a pipeline flush and holds the MEM stage idle until the trap handler acknowledges.

Parameters:
DATA_W, 32, ALU result / store data width
PC_W, 32, program counter width
REG_AW, 5, destination register index width
CNT_W, 8, overflow trap counter width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
ex_valid_i  input  1  EX stage holds a real instruction
ex_pc_i  input  PC_W  PC of the EX instruction
ex_alu_result_i  input  DATA_W  ALU result
ex_zero_i  input  1  ALU zero flag
ex_overflow_i  input  1  ALU overflow flag
ex_ovf_chk_i  input  1  instruction traps on overflow (signed add/sub)
ex_rt_data_i  input  DATA_W  store data
ex_wr_reg_i  input  REG_AW  destination register
ex_reg_write_i, ex_mem_read_i, ex_mem_write_i, ex_mem_to_reg_i, ex_branch_i  input  1 each  control bits
mem_stall_i  input  1  MEM stage stall; hold register contents
flush_i  input  1  external flush (branch resolution); insert bubble
trap_ack_i  input  1  trap handler acknowledge
mem_valid_o  output  1  MEM stage holds a real instruction
mem_pc_o  output  PC_W  registered PC
mem_alu_result_o  output  DATA_W  registered ALU result
mem_zero_o  output  1  registered zero flag
mem_rt_data_o  output  DATA_W  registered store data
mem_wr_reg_o  output  REG_AW  registered destination
mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o, mem_branch_o  output  1 each  registered control
trap_flush_o  output  1  one-cycle flush pulse to IF/ID/EX
trap_pending_o  output  1  trap outstanding
epc_o  output  PC_W  PC of the faulting instruction
cause_o  output  2  trap cause code
ovf_count_o  output  CNT_W  saturating count of overflow traps taken

Behaviour:
- Reset:
  - All outputs are 0; state is RUN; cause_o is CAUSE_NONE.
  - Reset overrides stall, flush and ack.
- Latency: 1 cycle from EX inputs to mem_*_o.
- Trap condition: trap = ex_valid_i & ex_ovf_chk_i & ex_overflow_i.
- Priority within RUN: rst_i, then mem_stall_i, then flush_i, then trap, then normal load.
- RUN, mem_stall_i=1:
  - Every register holds, including epc, cause and count.
  - flush_i and trap are ignored; upstream keeps them asserted until the stall clears.
- RUN, flush_i=1: bubble loaded.
  - mem_valid_o and all five control outputs are 0.
  - Data fields load the EX inputs; their values are don't-care.
  - No trap capture.
- RUN, trap:
  - Bubble loaded, so the faulting instruction writes neither the register file nor memory.
  - epc_o <= ex_pc_i; cause_o <= CAUSE_OVF.
  - ovf_count_o increments, saturating at all-ones.
  - Next state is TRAP_ISSUE.
- RUN, otherwise: all fields load the EX inputs.
- Unchecked overflow (ex_ovf_chk_i=0, e.g. addu/subu) loads normally; no trap.
- TRAP_ISSUE (exactly 1 cycle):
  - trap_flush_o=1 and trap_pending_o=1.
  - Bubble loaded regardless of inputs.
  - trap_ack_i ignored.
  - Next state is TRAP_WAIT.
- TRAP_WAIT:
  - trap_pending_o=1 and trap_flush_o=0.
  - A bubble is loaded every cycle; EX inputs, stall and flush_i are ignored.
  - On trap_ack_i=1: next state is RUN, cause_o <= CAUSE_NONE, epc_o holds.
- trap_flush_o is registered; it is 1 only while in TRAP_ISSUE.
- trap_pending_o = (state != RUN).
- No nested trap can occur, because inputs are ignored outside RUN.
- Reset during TRAP_ISSUE or TRAP_WAIT returns to RUN with all outputs 0, ovf_count_o included.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'd0, TRAP_ISSUE=2'd1, TRAP_WAIT=2'd2
  - cause codes: CAUSE_NONE=2'd0, CAUSE_OVF=2'd1
  - default widths
- One sub-module, ovf_trap_fsm, contains:
  - the state register and next-state logic
  - trap_flush_o and trap_pending_o
  - epc/cause capture and the saturating counter
  - a bubble/hold control output to the datapath register

Test Plan:
- Normal flow:
  - Stimulus: reset 2 cycles, then ex_valid_i=1, pc=0x40, result=0x1234, reg_write=1, wr_reg=5.
  - Response: next cycle mem_valid_o=1, mem_alu_result_o=0x1234, mem_wr_reg_o=5, trap_pending_o=0.
- Checked overflow:
  - Stimulus: pc=0x80, ovf_chk=1, overflow=1, reg_write=1.
  - Response: next cycle mem_valid_o=0, mem_reg_write_o=0, epc_o=0x80, cause_o=1, trap_flush_o=1, ovf_count_o=1; the cycle after, trap_flush_o=0 and trap_pending_o=1.
- Ack:
  - Stimulus: hold TRAP_WAIT 3 cycles with valid EX inputs, then trap_ack_i=1.
  - Response: mem_valid_o stays 0 throughout; next cycle trap_pending_o=0, cause_o=0, epc_o=0x80, and the next valid EX instruction loads.
- Unchecked overflow:
  - Stimulus: ovf_chk=0, overflow=1, mem_write=1.
  - Response: loads normally with mem_mem_write_o=1; no trap; counter unchanged.
- Stall and flush:
  - Stimulus: stall for 2 cycles with a changing EX overflow trap, then flush_i=1.
  - Response: outputs hold during the stall with no trap; the flush yields a bubble.
  - Stimulus: trap plus flush_i in the same cycle.
  - Response: bubble only; epc and count unchanged.
- Saturation and reset:
  - Stimulus: take 256 traps (ack each).
  - Response: ovf_count_o stays 255.
  - Stimulus: rst_i asserted in TRAP_WAIT.
  - Response: all outputs 0 the next cycle.
